// File: rtl/vga_pkg.sv
// Shared VGA raster helpers: line/frame totals, sync window bounds, 12-bit
// RGB444 pixel type and the eight-entry colour-bar table.
package vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam rgb444_t WHITE = '{r: 4'hF, g: 4'hF, b: 4'hF};
    localparam rgb444_t BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};

    // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black.
    localparam rgb444_t BAR_COLOURS [8] = '{
        WHITE,
        '{r: 4'hF, g: 4'hF, b: 4'h0},
        '{r: 4'h0, g: 4'hF, b: 4'hF},
        '{r: 4'h0, g: 4'hF, b: 4'h0},
        '{r: 4'hF, g: 4'h0, b: 4'hF},
        '{r: 4'hF, g: 4'h0, b: 4'h0},
        '{r: 4'h0, g: 4'h0, b: 4'hF},
        BLACK
    };

    function automatic int line_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int vis, input int fp);
        return vis + fp;
    endfunction

    function automatic int sync_end(input int vis, input int fp, input int sync);
        return vis + fp + sync;
    endfunction

endpackage

// File: rtl/vga_test_pattern_if.sv
// VGA connector bundle: 4-bit R/G/B, both syncs and the frame-counter LEDs.
interface vga_test_pattern_if;
    logic [3:0] VGA_R;
    logic [3:0] VGA_G;
    logic [3:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic [9:0] LEDR;

    modport master (output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, LEDR);
    modport slave  (input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, LEDR);
endinterface

// File: rtl/vga_timing_counter.sv
// Free-running h/v raster counters with sync-window, active-video and frame-end
// decode. With VGA_TEST_BORDER_EN defined it also flags the outermost visible pixels.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_VISIBLE_AREA = 800,
    parameter int H_FRONT_PORCH  = 40,
    parameter int H_SYNC_PULSE   = 128,
    parameter int H_BACK_PORCH   = 88,
    parameter int V_VISIBLE_AREA = 600,
    parameter int V_FRONT_PORCH  = 1,
    parameter int V_SYNC_PULSE   = 4,
    parameter int V_BACK_PORCH   = 23,
    localparam int H_TOTAL = line_total(H_VISIBLE_AREA, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH),
    localparam int V_TOTAL = line_total(V_VISIBLE_AREA, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH),
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h_p0,
    output logic          hsync_win,
    output logic          vsync_win,
    output logic          vld,
    output logic          frame_end
`ifdef VGA_TEST_BORDER_EN
    ,
    output logic          border
`endif
);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE_AREA);
    localparam logic [HW-1:0] HS_START = HW'(sync_start(H_VISIBLE_AREA, H_FRONT_PORCH));
    localparam logic [HW-1:0] HS_END   = HW'(sync_end(H_VISIBLE_AREA, H_FRONT_PORCH, H_SYNC_PULSE));
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE_AREA);
    localparam logic [VW-1:0] VS_START = VW'(sync_start(V_VISIBLE_AREA, V_FRONT_PORCH));
    localparam logic [VW-1:0] VS_END   = VW'(sync_end(V_VISIBLE_AREA, V_FRONT_PORCH, V_SYNC_PULSE));

    logic [VW-1:0] v_p0;
    logic          h_wrap;
    logic          v_wrap;

    assign h_wrap = (h_p0 == H_LAST);
    assign v_wrap = (v_p0 == V_LAST);

    // Stage p0: raster position
    always_ff @(posedge clk) begin
        if (rst) begin
            h_p0 <= '0;
            v_p0 <= '0;
        end else if (h_wrap) begin
            h_p0 <= '0;
            v_p0 <= v_wrap ? '0 : v_p0 + 1'b1;
        end else begin
            h_p0 <= h_p0 + 1'b1;
        end
    end

    assign hsync_win = (h_p0 >= HS_START) && (h_p0 < HS_END);
    assign vsync_win = (v_p0 >= VS_START) && (v_p0 < VS_END);
    assign vld       = (h_p0 < H_VIS) && (v_p0 < V_VIS);
    assign frame_end = h_wrap && v_wrap;

`ifdef VGA_TEST_BORDER_EN
    localparam logic [HW-1:0] H_VIS_LAST = HW'(H_VISIBLE_AREA - 1);
    localparam logic [VW-1:0] V_VIS_LAST = VW'(V_VISIBLE_AREA - 1);

    assign border = (h_p0 == '0) || (h_p0 == H_VIS_LAST) || (v_p0 == '0) || (v_p0 == V_VIS_LAST);
`endif

endmodule

// File: rtl/vga_test_pattern.sv
// VGA timing generator with an 8-bar colour test pattern and 10-bit frame counter.
// Define VGA_TEST_BORDER_EN to overlay a 1-pixel white border on the visible area.
module vga_test_pattern
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE_AREA = 800,
    parameter int   H_FRONT_PORCH  = 40,
    parameter int   H_SYNC_PULSE   = 128,
    parameter int   H_BACK_PORCH   = 88,
    parameter int   V_VISIBLE_AREA = 600,
    parameter int   V_FRONT_PORCH  = 1,
    parameter int   V_SYNC_PULSE   = 4,
    parameter int   V_BACK_PORCH   = 23,
    parameter logic HSYNC_POLARITY = 1'b0,
    parameter logic VSYNC_POLARITY = 1'b0
) (
    input  logic               VGA_CLK,
    input  logic               RESET,
    vga_test_pattern_if.master vga
);
    localparam int H_TOTAL = line_total(H_VISIBLE_AREA, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH);
    localparam int HW      = $clog2(H_TOTAL);
    localparam logic [HW-1:0] BAR_W    = HW'(H_VISIBLE_AREA / 8);
    localparam logic [HW-1:0] LAST_BAR = HW'(7);

    logic [HW-1:0] h_p0;
    logic          hsync_win_p0;
    logic          vsync_win_p0;
    logic          vld_p0;
    logic          frame_end_p0;
    rgb444_t       pixel_p0;
    rgb444_t       rgb_p1;
    logic          hs_p1;
    logic          vs_p1;
    logic [9:0]    frame_cnt_p1;
`ifdef VGA_TEST_BORDER_EN
    logic          border_p0;
`endif

    vga_timing_counter #(
        .H_VISIBLE_AREA (H_VISIBLE_AREA),
        .H_FRONT_PORCH  (H_FRONT_PORCH),
        .H_SYNC_PULSE   (H_SYNC_PULSE),
        .H_BACK_PORCH   (H_BACK_PORCH),
        .V_VISIBLE_AREA (V_VISIBLE_AREA),
        .V_FRONT_PORCH  (V_FRONT_PORCH),
        .V_SYNC_PULSE   (V_SYNC_PULSE),
        .V_BACK_PORCH   (V_BACK_PORCH)
    ) u_timing (
        .clk       (VGA_CLK),
        .rst       (RESET),
        .h_p0      (h_p0),
        .hsync_win (hsync_win_p0),
        .vsync_win (vsync_win_p0),
        .vld       (vld_p0),
        .frame_end (frame_end_p0)
`ifdef VGA_TEST_BORDER_EN
        ,
        .border    (border_p0)
`endif
    );

    // Leftover pixels past the eighth full bar saturate into the last bar.
    function automatic rgb444_t bar_colour(input logic [HW-1:0] h);
        logic [HW-1:0] idx;
        idx = h / BAR_W;
        return (idx > LAST_BAR) ? BAR_COLOURS[7] : BAR_COLOURS[idx[2:0]];
    endfunction

    always_comb begin
        pixel_p0 = BLACK;
        if (vld_p0) begin
            pixel_p0 = bar_colour(h_p0);
`ifdef VGA_TEST_BORDER_EN
            if (border_p0) pixel_p0 = WHITE;
`endif
        end
    end

    // Stage p1: registered pins, one cycle behind the raster position
    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            rgb_p1       <= BLACK;
            hs_p1        <= HSYNC_POLARITY;
            vs_p1        <= VSYNC_POLARITY;
            frame_cnt_p1 <= '0;
        end else begin
            rgb_p1 <= pixel_p0;
            hs_p1  <= HSYNC_POLARITY ^ hsync_win_p0;
            vs_p1  <= VSYNC_POLARITY ^ vsync_win_p0;
            if (frame_end_p0) frame_cnt_p1 <= frame_cnt_p1 + 1'b1;
        end
    end

    assign vga.VGA_R  = rgb_p1.r;
    assign vga.VGA_G  = rgb_p1.g;
    assign vga.VGA_B  = rgb_p1.b;
    assign vga.VGA_HS = hs_p1;
    assign vga.VGA_VS = vs_p1;
    assign vga.LEDR   = frame_cnt_p1;

endmodule

// File: tb/tb_vga_test_pattern.sv
// Bench for vga_test_pattern: per-cycle scoreboard on a full-size and a reduced raster,
// plus sync timing, colour-bar, mid-frame reset and frame-counter wrap checks.
module tb_vga_test_pattern;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic [9:0]  led;
    } obs_t;

    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                         12'hF0F, 12'hF00, 12'h00F, 12'h000};
`ifdef VGA_TEST_BORDER_EN
    localparam logic [11:0] EDGE_PX = 12'hFFF;
`else
    localparam logic [11:0] EDGE_PX = 12'h000;
`endif

    localparam int D_HT = 1056;
    localparam int D_VT = 628;
    localparam int S_HV = 18, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VV = 6,  S_VF = 1, S_VS = 2, S_VB = 1;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
    localparam int S_FRAME = S_HT * S_VT;
    localparam int T_FRAME = 11 * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b1;
    logic rst_s = 1'b1;

    vga_test_pattern_if vif_d ();
    vga_test_pattern_if vif_s ();
    vga_test_pattern_if vif_t ();

    vga_test_pattern dut (.VGA_CLK(clk), .RESET(rst_d), .vga(vif_d));

    vga_test_pattern #(
        .H_VISIBLE_AREA(S_HV), .H_FRONT_PORCH(S_HF), .H_SYNC_PULSE(S_HS), .H_BACK_PORCH(S_HB),
        .V_VISIBLE_AREA(S_VV), .V_FRONT_PORCH(S_VF), .V_SYNC_PULSE(S_VS), .V_BACK_PORCH(S_VB),
        .HSYNC_POLARITY(1'b1), .VSYNC_POLARITY(1'b1)
    ) dut_s (.VGA_CLK(clk), .RESET(rst_s), .vga(vif_s));

    vga_test_pattern #(
        .H_VISIBLE_AREA(8), .H_FRONT_PORCH(1), .H_SYNC_PULSE(1), .H_BACK_PORCH(1),
        .V_VISIBLE_AREA(1), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1),
        .HSYNC_POLARITY(1'b0), .VSYNC_POLARITY(1'b0)
    ) dut_t (.VGA_CLK(clk), .RESET(rst_d), .vga(vif_t));

    int n_cmp = 0;
    int n_fail = 0;
    obs_t q_d[$];
    obs_t q_s[$];

    int dh = 0, dv = 0, sh = 0, sv = 0;
    logic [9:0] dled = '0, sled = '0;
    int cyc_d = 0, cyc_s = 0;

    logic [11:0] line0_d [1056];
    logic [11:0] line0_s [S_HT];

    logic prev_hs_d = 1'b0, prev_hs_s = 1'b0, prev_vs_s = 1'b0;
    int hs_rise_d = -1, hs_width_d = -1, hs_per_d = -1, hs_last_d = -1;
    int hs_rise_s = -1, hs_width_s = -1, hs_per_s = -1, hs_last_s = -1;
    int vs_rise_s = -1, vs_width_s = -1, vs_per_s = -1, vs_last_s = -1;

    logic [9:0] s_led_a = 'x, s_led_b = 'x;
    logic [9:0] t_led_a = 'x, t_led_b = 'x, t_led_c = 'x;

    function automatic obs_t model(input int h, input int v, input int hv, input int hf, input int hsw,
                                   input int vv, input int vf, input int vsw, input logic hp, input logic vp);
        obs_t o;
        int   i;
        o    = '0;
        o.hs = hp ^ ((h >= hv + hf) && (h < hv + hf + hsw));
        o.vs = vp ^ ((v >= vv + vf) && (v < vv + vf + vsw));
        if (h < hv && v < vv) begin
            i = h / (hv / 8);
            if (i > 7) i = 7;
            o.rgb = BARS[i[2:0]];
`ifdef VGA_TEST_BORDER_EN
            if (h == 0 || h == hv - 1 || v == 0 || v == vv - 1) o.rgb = 12'hFFF;
`endif
        end
        return o;
    endfunction

    task automatic advance(inout int h, inout int v, inout logic [9:0] led, input int ht, input int vt);
        if (h == ht - 1) begin
            h = 0;
            if (v == vt - 1) begin
                v   = 0;
                led = led + 10'd1;
            end else begin
                v++;
            end
        end else begin
            h++;
        end
    endtask

    task automatic measure(input logic act, input logic prev, input int cyc,
                           inout int rise, inout int width, inout int per, inout int last);
        if (act && !prev) begin
            if (rise < 0) rise = cyc;
            else if (per < 0) per = cyc - last;
            last = cyc;
        end
        if (!act && prev && width < 0 && rise >= 0) width = cyc - last;
    endtask

    task automatic check_obs(input string tag, input obs_t o, input obs_t e);
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed rgb=%h hs=%b vs=%b led=%0d, expected rgb=%h hs=%b vs=%b led=%0d",
                   tag, o.rgb, o.hs, o.vs, o.led, e.rgb, e.hs, e.vs, e.led);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%h), expected %0d (0x%h)", tag, o, o, e, e);
        end
    endtask

    task automatic tick();
        obs_t ed, es, od, os;
        if (rst_d) ed = '{12'h000, 1'b0, 1'b0, 10'd0};
        else begin
            ed     = model(dh, dv, 800, 40, 128, 600, 1, 4, 1'b0, 1'b0);
            ed.led = (dh == D_HT - 1 && dv == D_VT - 1) ? dled + 10'd1 : dled;
        end
        q_d.push_back(ed);
        if (rst_s) es = '{12'h000, 1'b1, 1'b1, 10'd0};
        else begin
            es     = model(sh, sv, S_HV, S_HF, S_HS, S_VV, S_VF, S_VS, 1'b1, 1'b1);
            es.led = (sh == S_HT - 1 && sv == S_VT - 1) ? sled + 10'd1 : sled;
        end
        q_s.push_back(es);

        @(posedge clk);
        if (rst_d) begin dh = 0; dv = 0; dled = '0; cyc_d = 0; end
        else begin advance(dh, dv, dled, D_HT, D_VT); cyc_d++; end
        if (rst_s) begin sh = 0; sv = 0; sled = '0; cyc_s = 0; end
        else begin advance(sh, sv, sled, S_HT, S_VT); cyc_s++; end

        @(negedge clk);
        od = '{{vif_d.VGA_R, vif_d.VGA_G, vif_d.VGA_B}, vif_d.VGA_HS, vif_d.VGA_VS, vif_d.LEDR};
        os = '{{vif_s.VGA_R, vif_s.VGA_G, vif_s.VGA_B}, vif_s.VGA_HS, vif_s.VGA_VS, vif_s.LEDR};
        check_obs("sb_default", od, q_d.pop_front());
        check_obs("sb_small", os, q_s.pop_front());

        if (rst_d) prev_hs_d = 1'b0;
        else begin
            measure(vif_d.VGA_HS, prev_hs_d, cyc_d, hs_rise_d, hs_width_d, hs_per_d, hs_last_d);
            prev_hs_d = vif_d.VGA_HS;
            if (cyc_d >= 1 && cyc_d <= D_HT) line0_d[11'(cyc_d - 1)] = od.rgb;
            if (cyc_d == 1024 * T_FRAME - 1) t_led_a = vif_t.LEDR;
            if (cyc_d == 1024 * T_FRAME)     t_led_b = vif_t.LEDR;
            if (cyc_d == 1025 * T_FRAME)     t_led_c = vif_t.LEDR;
        end
        if (rst_s) begin
            prev_hs_s = 1'b0;
            prev_vs_s = 1'b0;
        end else begin
            measure(~vif_s.VGA_HS, prev_hs_s, cyc_s, hs_rise_s, hs_width_s, hs_per_s, hs_last_s);
            measure(~vif_s.VGA_VS, prev_vs_s, cyc_s, vs_rise_s, vs_width_s, vs_per_s, vs_last_s);
            prev_hs_s = ~vif_s.VGA_HS;
            prev_vs_s = ~vif_s.VGA_VS;
            if (cyc_s >= 1 && cyc_s <= S_HT) line0_s[5'(cyc_s - 1)] = os.rgb;
            if (cyc_s == S_FRAME - 1) s_led_a = vif_s.LEDR;
            if (cyc_s == S_FRAME)     s_led_b = vif_s.LEDR;
        end
    endtask

    initial begin
        int n;
        int nz;

        // Reset held for five clocks
        repeat (5) tick();
        check_val("rst_hs_default", 32'(vif_d.VGA_HS), 32'd0);
        check_val("rst_vs_default", 32'(vif_d.VGA_VS), 32'd0);
        check_val("rst_rgb_default", 32'({vif_d.VGA_R, vif_d.VGA_G, vif_d.VGA_B}), 32'd0);
        check_val("rst_led_default", 32'(vif_d.LEDR), 32'd0);
        check_val("rst_hs_negpol", 32'(vif_s.VGA_HS), 32'd1);
        check_val("rst_vs_negpol", 32'(vif_s.VGA_VS), 32'd1);

        // Free run: three full-size lines, a dozen reduced frames
        rst_d = 1'b0;
        rst_s = 1'b0;
        repeat (3200) tick();
        check_val("hs_first_rise", hs_rise_d, 841);
        check_val("hs_width", hs_width_d, 128);
        check_val("hs_period", hs_per_d, 1056);
        check_val("hs_small_rise", hs_rise_s, S_HV + S_HF + 1);
        check_val("hs_small_width", hs_width_s, S_HS);
        check_val("hs_small_period", hs_per_s, S_HT);
        check_val("vs_small_rise", vs_rise_s, (S_VV + S_VF) * S_HT + 1);
        check_val("vs_small_width", vs_width_s, S_VS * S_HT);
        check_val("vs_small_period", vs_per_s, S_FRAME);

        check_val("px0", 32'(line0_d[0]), 32'h0FFF);
        check_val("px150", 32'(line0_d[150]), 32'h0FF0);
        check_val("px300", 32'(line0_d[300]), 32'h00F0);
        check_val("px799", 32'(line0_d[799]), 32'(EDGE_PX));
        nz = 0;
        for (int p = 800; p < 1056; p++) if (line0_d[p] !== 12'h000) nz++;
        check_val("blank_800_1055", nz, 0);
        check_val("small_px2", 32'(line0_s[2]), 32'h0FF0);
        check_val("small_px16_clamp", 32'(line0_s[16]), 32'h0000);
        check_val("small_px17_clamp", 32'(line0_s[17]), 32'(EDGE_PX));
        check_val("small_led_run", 32'(vif_s.LEDR), cyc_s / S_FRAME);

        // Mid-frame reset of the reduced raster at line 3
        n = 0;
        while (sv != 3 && n < 2 * S_FRAME) begin
            tick();
            n++;
        end
        check_val("reach_line3", sv, 3);
        rst_s = 1'b1;
        tick();
        tick();
        check_val("midrst_led", 32'(vif_s.LEDR), 32'd0);
        check_val("midrst_vs_idle", 32'(vif_s.VGA_VS), 32'd1);
        vs_rise_s = -1; vs_width_s = -1; vs_per_s = -1; vs_last_s = -1;
        s_led_a = 'x;
        s_led_b = 'x;
        rst_s = 1'b0;
        repeat (S_FRAME + 40) tick();
        check_val("midrst_vs_rise", vs_rise_s, (S_VV + S_VF) * S_HT + 1);
        check_val("midrst_led_before_wrap", 32'(s_led_a), 32'd0);
        check_val("midrst_led_after_frame", 32'(s_led_b), 32'd1);

        // Frame counter wrap on the tiny raster
        while (cyc_d < 1025 * T_FRAME + 2) tick();
        check_val("led_1023", 32'(t_led_a), 32'd1023);
        check_val("led_wrap_0", 32'(t_led_b), 32'd0);
        check_val("led_after_wrap_1", 32'(t_led_c), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
